lsu_mem_stage: RTL and testbench

Load/store stage directly downstream of the execute ALU. It takes the ALU effective address (the adder output) plus the store data and access type, then checks alignment and issues a single word-aligned request to the data-memory port. Load data is lane-aligned and sign/zero-extended, then returned to writeback with exception status. Only one access is in flight at a time, and the block is not pipelined.

---
 rtl/lsu_mem_stage_pkg.sv | 34 +++
 rtl/lsu_mem_stage_if.sv | 52 +++++
 rtl/lsu_mem_stage_align.sv | 56 +++++
 rtl/lsu_mem_stage.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the load/store memory stage: access sizes, trap causes, FSM states.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [3:0] CAUSE_NONE     = 4'd0;
    localparam logic [3:0] CAUSE_LD_MISAL = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Map an access direction and failure kind onto the RISC-V trap cause.
    function automatic logic [3:0] fault_cause(input logic is_store, input logic is_misal);
        logic [3:0] cause;
        if (is_misal) begin
            cause = is_store ? CAUSE_ST_MISAL : CAUSE_LD_MISAL;
        end else begin
            cause = is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        end
        return cause;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Execute-side request, data-memory port and writeback response bundle of the load/store stage.
interface lsu_mem_stage_if;
    import lsu_pkg::*;

    logic                io_req_valid;
    logic                io_req_ready;
    logic [LSU_XLEN-1:0] io_req_addr;
    logic [LSU_XLEN-1:0] io_req_wdata;
    logic                io_req_cmd;
    logic [1:0]          io_req_size;
    logic                io_req_signed;
    logic [4:0]          io_req_rd;

    logic                io_mem_req_valid;
    logic                io_mem_req_ready;
    logic [LSU_XLEN-1:0] io_mem_req_addr;
    logic                io_mem_req_we;
    logic [3:0]          io_mem_req_wstrb;
    logic [LSU_XLEN-1:0] io_mem_req_wdata;
    logic                io_mem_resp_valid;
    logic [LSU_XLEN-1:0] io_mem_resp_rdata;
    logic                io_mem_resp_err;

    logic                io_resp_valid;
    logic [LSU_XLEN-1:0] io_resp_data;
    logic [4:0]          io_resp_rd;
    logic                io_resp_exc;
    logic [3:0]          io_resp_cause;

    // The load/store stage itself.
    modport slave (
        input  io_req_valid, io_req_addr, io_req_wdata, io_req_cmd,
        input  io_req_size, io_req_signed, io_req_rd,
        output io_req_ready,
        output io_mem_req_valid, io_mem_req_addr, io_mem_req_we,
        output io_mem_req_wstrb, io_mem_req_wdata,
        input  io_mem_req_ready, io_mem_resp_valid, io_mem_resp_rdata, io_mem_resp_err,
        output io_resp_valid, io_resp_data, io_resp_rd, io_resp_exc, io_resp_cause
    );

    // Execute stage, data memory and writeback seen together.
    modport master (
        output io_req_valid, io_req_addr, io_req_wdata, io_req_cmd,
        output io_req_size, io_req_signed, io_req_rd,
        input  io_req_ready,
        input  io_mem_req_valid, io_mem_req_addr, io_mem_req_we,
        input  io_mem_req_wstrb, io_mem_req_wdata,
        output io_mem_req_ready, io_mem_resp_valid, io_mem_resp_rdata, io_mem_resp_err,
        input  io_resp_valid, io_resp_data, io_resp_rd, io_resp_exc, io_resp_cause
    );

endinterface

// File: rtl/lsu_mem_stage_align.sv
// Combinational lane logic: store strobes and lane shift, misalignment check, load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]          i_req_addr_lo,
    input  logic [1:0]          i_req_size,
    input  logic [LSU_XLEN-1:0] i_req_wdata,
    output logic [3:0]          o_wstrb,
    output logic [LSU_XLEN-1:0] o_wdata,
    output logic                o_misal,

    input  logic [1:0]          i_rsp_addr_lo,
    input  logic [1:0]          i_rsp_size,
    input  logic                i_rsp_signed,
    input  logic [LSU_XLEN-1:0] i_rdata,
    output logic [LSU_XLEN-1:0] o_load_data
);

    logic [LSU_XLEN-1:0] w_rshift;
    logic                w_sign_b;
    logic                w_sign_h;

    always_comb begin
        o_wstrb = 4'b0000;
        o_misal = 1'b0;
        case (i_req_size)
            SZ_B: o_wstrb = 4'b0001 << i_req_addr_lo;
            SZ_H: begin
                o_wstrb = 4'b0011 << i_req_addr_lo;
                o_misal = i_req_addr_lo[0];
            end
            SZ_W: begin
                o_wstrb = 4'b1111;
                o_misal = (i_req_addr_lo != 2'b00);
            end
            default: o_misal = 1'b1;
        endcase
    end

    // Store data is shifted into its byte lanes; strobes select the live bytes.
    assign o_wdata  = i_req_wdata << {i_req_addr_lo, 3'b000};

    assign w_rshift = i_rdata >> {i_rsp_addr_lo, 3'b000};
    assign w_sign_b = i_rsp_signed & w_rshift[7];
    assign w_sign_h = i_rsp_signed & w_rshift[15];

    always_comb begin
        o_load_data = w_rshift;
        case (i_rsp_size)
            SZ_B:    o_load_data = {{24{w_sign_b}}, w_rshift[7:0]};
            SZ_H:    o_load_data = {{16{w_sign_h}}, w_rshift[15:0]};
            default: o_load_data = w_rshift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Single-outstanding load/store stage between execute and the data-memory port.
// Optional WAIT timeout enabled with `define LSU_TIMEOUT_EN.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clock,
    input  logic           reset,
    lsu_mem_stage_if.slave bus
);

    lsu_state_e      r_state;

    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [3:0]      r_mem_wstrb;
    logic            r_mem_we;

    logic [1:0]      r_addr_lo;
    logic [1:0]      r_size;
    logic            r_signed;
    logic [4:0]      r_rd;

    logic [XLEN-1:0] r_resp_data;
    logic [4:0]      r_resp_rd;
    logic            r_resp_exc;
    logic [3:0]      r_resp_cause;

    logic            w_accept;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;
    logic            w_misal;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]      r_wait_cnt;
`endif

    assign w_accept = bus.io_req_valid && (r_state == ST_IDLE);

    lsu_align u_align (
        .i_req_addr_lo (bus.io_req_addr[1:0]),
        .i_req_size    (bus.io_req_size),
        .i_req_wdata   (bus.io_req_wdata),
        .o_wstrb       (w_wstrb),
        .o_wdata       (w_wdata),
        .o_misal       (w_misal),
        .i_rsp_addr_lo (r_addr_lo),
        .i_rsp_size    (r_size),
        .i_rsp_signed  (r_signed),
        .i_rdata       (bus.io_mem_resp_rdata),
        .o_load_data   (w_load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= 4'b0000;
            r_mem_we     <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_rd         <= 5'd0;
            r_resp_data  <= '0;
            r_resp_rd    <= 5'd0;
            r_resp_exc   <= 1'b0;
            r_resp_cause <= CAUSE_NONE;
`ifdef LSU_TIMEOUT_EN
            r_wait_cnt   <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Loads drive no strobes so the memory never sees a partial write.
                        r_mem_addr  <= {bus.io_req_addr[XLEN-1:2], 2'b00};
                        r_mem_we    <= bus.io_req_cmd;
                        r_mem_wstrb <= bus.io_req_cmd ? w_wstrb : 4'b0000;
                        r_mem_wdata <= w_wdata;
                        r_addr_lo   <= bus.io_req_addr[1:0];
                        r_size      <= bus.io_req_size;
                        r_signed    <= bus.io_req_signed;
                        r_rd        <= bus.io_req_rd;
                        if (w_misal) begin
                            r_resp_data  <= '0;
                            r_resp_rd    <= bus.io_req_cmd ? 5'd0 : bus.io_req_rd;
                            r_resp_exc   <= 1'b1;
                            r_resp_cause <= fault_cause(bus.io_req_cmd, 1'b1);
                            r_state      <= ST_RESP;
                        end else begin
                            r_state      <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    if (bus.io_mem_req_ready) begin
                        r_state    <= ST_WAIT;
`ifdef LSU_TIMEOUT_EN
                        r_wait_cnt <= 8'd0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (bus.io_mem_resp_valid) begin
                        r_resp_data  <= (bus.io_mem_resp_err || r_mem_we) ? '0 : w_load_data;
                        r_resp_rd    <= r_mem_we ? 5'd0 : r_rd;
                        r_resp_exc   <= bus.io_mem_resp_err;
                        r_resp_cause <= bus.io_mem_resp_err ? fault_cause(r_mem_we, 1'b0)
                                                            : CAUSE_NONE;
                        r_state      <= ST_RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_wait_cnt == TIMEOUT_LAST) begin
                        // A silent memory is reported as an access fault.
                        r_resp_data  <= '0;
                        r_resp_rd    <= r_mem_we ? 5'd0 : r_rd;
                        r_resp_exc   <= 1'b1;
                        r_resp_cause <= fault_cause(r_mem_we, 1'b0);
                        r_state      <= ST_RESP;
                    end else begin
                        r_wait_cnt   <= r_wait_cnt + 8'd1;
                    end
`endif
                end

                ST_RESP: r_state <= ST_IDLE;

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.io_req_ready     = (r_state == ST_IDLE);
    assign bus.io_mem_req_valid = (r_state == ST_REQ);
    assign bus.io_mem_req_addr  = r_mem_addr;
    assign bus.io_mem_req_we    = r_mem_we;
    assign bus.io_mem_req_wstrb = r_mem_wstrb;
    assign bus.io_mem_req_wdata = r_mem_wdata;

    assign bus.io_resp_valid    = (r_state == ST_RESP);
    assign bus.io_resp_data     = r_resp_data;
    assign bus.io_resp_rd       = r_resp_rd;
    assign bus.io_resp_exc      = r_resp_exc;
    assign bus.io_resp_cause    = r_resp_cause;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: expected responses queued at issue, checked on io_resp_valid.
// Define LSU_TIMEOUT_EN to also cover the WAIT timeout path.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    lsu_mem_stage_if io ();

    lsu_mem_stage #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (io)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exc;
        logic [3:0]  cause;
        int          lat;
        bit          has_mem;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic        we;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] data, input logic [4:0] rd, input logic exc,
                                input logic [3:0] cause, input int lat, input bit has_mem,
                                input logic [31:0] maddr, input logic [3:0] wstrb,
                                input logic [31:0] mwdata, input logic we);
        exp_t e;
        e.data = data; e.rd = rd; e.exc = exc; e.cause = cause; e.lat = lat;
        e.has_mem = has_mem; e.maddr = maddr; e.wstrb = wstrb; e.mwdata = mwdata; e.we = we;
        return e;
    endfunction

    // Called at a falling edge with the DUT idle; returns 1ns after the accepting edge.
    task automatic send(input logic cmd, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input bit push, input exp_t e);
        chk("req_ready_idle", 32'(io.io_req_ready), 32'd1);
        io.io_req_valid  = 1'b1;
        io.io_req_cmd    = cmd;
        io.io_req_size   = size;
        io.io_req_signed = sgn;
        io.io_req_addr   = addr;
        io.io_req_wdata  = wdata;
        io.io_req_rd     = rd;
        if (push) sb_q.push_back(e);
        @(posedge clock);
        #1;
        io.io_req_valid  = 1'b0;
    endtask

    task automatic collect(input string tag, input int budget);
        exp_t e;
        bit   got;
        bit   mem_seen;
        int   n;
        got = 1'b0;
        mem_seen = 1'b0;
        n = 0;
        chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        while (!got && n < budget) begin
            @(negedge clock);
            n++;
            if (!e.has_mem) begin
                chk({tag, "_no_mem_req"}, 32'(io.io_mem_req_valid), 32'd0);
            end else if (io.io_mem_req_valid && !mem_seen) begin
                mem_seen = 1'b1;
                chk({tag, "_mem_addr"},  io.io_mem_req_addr, e.maddr);
                chk({tag, "_mem_wstrb"}, 32'(io.io_mem_req_wstrb), 32'(e.wstrb));
                chk({tag, "_mem_wdata"}, io.io_mem_req_wdata, e.mwdata);
                chk({tag, "_mem_we"},    32'(io.io_mem_req_we), 32'(e.we));
            end
            if (io.io_resp_valid) begin
                got = 1'b1;
                $display("[TB] %s: cycle %0d data=%h rd=%0d exc=%0d cause=%0d", tag, n,
                         io.io_resp_data, io.io_resp_rd, io.io_resp_exc, io.io_resp_cause);
                chk({tag, "_data"},  io.io_resp_data, e.data);
                chk({tag, "_rd"},    32'(io.io_resp_rd), 32'(e.rd));
                chk({tag, "_exc"},   32'(io.io_resp_exc), 32'(e.exc));
                chk({tag, "_cause"}, 32'(io.io_resp_cause), 32'(e.cause));
                if (e.lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(e.lat));
            end
        end
        chk({tag, "_resp_seen"}, 32'(got), 32'd1);
        if (e.has_mem && e.lat >= 0) chk({tag, "_mem_req_seen"}, 32'(mem_seen), 32'd1);
        @(negedge clock);
        chk({tag, "_pulse_end"}, 32'(io.io_resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io.io_req_valid      = 1'b0;
        io.io_req_cmd        = 1'b0;
        io.io_req_size       = 2'd0;
        io.io_req_signed     = 1'b0;
        io.io_req_addr       = 32'h0;
        io.io_req_wdata      = 32'h0;
        io.io_req_rd         = 5'd0;
        io.io_mem_req_ready  = 1'b1;
        io.io_mem_resp_valid = 1'b1;
        io.io_mem_resp_rdata = 32'h0;
        io.io_mem_resp_err   = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_req_ready",     32'(io.io_req_ready), 32'd1);
        chk("rst_mem_req_valid", 32'(io.io_mem_req_valid), 32'd0);
        chk("rst_resp_valid",    32'(io.io_resp_valid), 32'd0);
        chk("rst_resp_data",     io.io_resp_data, 32'h0);
        chk("rst_resp_exc",      32'(io.io_resp_exc), 32'd0);
        chk("rst_resp_cause",    32'(io.io_resp_cause), 32'd0);
        chk("rst_mem_wstrb",     32'(io.io_mem_req_wstrb), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready",    32'(io.io_req_ready), 32'd1);

        // Loads with memory always ready and responding: lane extract and extension.
        io.io_mem_resp_rdata = 32'h8012_3456;
        send(1'b0, SZ_B, 1'b1, 32'h1003, 32'h0, 5'd5, 1'b1,
             mk(32'hFFFF_FF80, 5'd5, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b0000, 32'h0, 1'b0));
        collect("lb_s_1003", 10);
        send(1'b0, SZ_B, 1'b0, 32'h1003, 32'h0, 5'd6, 1'b1,
             mk(32'h0000_0080, 5'd6, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b0000, 32'h0, 1'b0));
        collect("lbu_1003", 10);
        send(1'b0, SZ_B, 1'b1, 32'h1001, 32'h0, 5'd8, 1'b1,
             mk(32'h0000_0034, 5'd8, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b0000, 32'h0, 1'b0));
        collect("lb_s_1001", 10);
        send(1'b0, SZ_H, 1'b1, 32'h1002, 32'h0, 5'd1, 1'b1,
             mk(32'hFFFF_8012, 5'd1, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b0000, 32'h0, 1'b0));
        collect("lh_s_1002", 10);
        send(1'b0, SZ_H, 1'b0, 32'h1002, 32'h0, 5'd2, 1'b1,
             mk(32'h0000_8012, 5'd2, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b0000, 32'h0, 1'b0));
        collect("lhu_1002", 10);
        send(1'b0, SZ_W, 1'b0, 32'h1000, 32'h0, 5'd31, 1'b1,
             mk(32'h8012_3456, 5'd31, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b0000, 32'h0, 1'b0));
        collect("lw_1000", 10);

        // Stores: strobes and lane-shifted data.
        send(1'b1, SZ_H, 1'b0, 32'h1002, 32'h0000_BEEF, 5'd7, 1'b1,
             mk(32'h0, 5'd0, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b1100, 32'hBEEF_0000, 1'b1));
        collect("sh_1002", 10);
        send(1'b1, SZ_B, 1'b0, 32'h1001, 32'h1234_56A5, 5'd7, 1'b1,
             mk(32'h0, 5'd0, 1'b0, 4'd0, 3, 1'b1, 32'h1000, 4'b0010, 32'h3456_A500, 1'b1));
        collect("sb_1001", 10);
        send(1'b1, SZ_W, 1'b0, 32'h1004, 32'hDEAD_BEEF, 5'd7, 1'b1,
             mk(32'h0, 5'd0, 1'b0, 4'd0, 3, 1'b1, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 1'b1));
        collect("sw_1004", 10);

        // Misaligned and illegal-size accesses complete without touching memory.
        send(1'b0, SZ_W, 1'b0, 32'h1002, 32'h0, 5'd3, 1'b1,
             mk(32'h0, 5'd3, 1'b1, 4'd4, 1, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0));
        collect("lw_misal", 10);
        send(1'b1, SZ_W, 1'b0, 32'h1001, 32'h5555_AAAA, 5'd9, 1'b1,
             mk(32'h0, 5'd0, 1'b1, 4'd6, 1, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0));
        collect("sw_misal", 10);
        send(1'b0, SZ_H, 1'b1, 32'h1001, 32'h0, 5'd4, 1'b1,
             mk(32'h0, 5'd4, 1'b1, 4'd4, 1, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0));
        collect("lh_misal", 10);
        send(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 5'd2, 1'b1,
             mk(32'h0, 5'd2, 1'b1, 4'd4, 1, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0));
        collect("ld_size3", 10);
        send(1'b1, 2'd3, 1'b0, 32'h1000, 32'h0, 5'd2, 1'b1,
             mk(32'h0, 5'd0, 1'b1, 4'd6, 1, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0));
        collect("st_size3", 10);

        // Memory stalls the request for five cycles.
        io.io_mem_req_ready = 1'b0;
        send(1'b1, SZ_W, 1'b0, 32'h2004, 32'hCAFE_F00D, 5'd1, 1'b1,
             mk(32'h0, 5'd0, 1'b0, 4'd0, -1, 1'b1, 32'h2004, 4'b1111, 32'hCAFE_F00D, 1'b1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_mem_valid", 32'(io.io_mem_req_valid), 32'd1);
            chk("stall_mem_addr",  io.io_mem_req_addr, 32'h2004);
            chk("stall_mem_wdata", io.io_mem_req_wdata, 32'hCAFE_F00D);
            chk("stall_req_ready", 32'(io.io_req_ready), 32'd0);
        end
        io.io_mem_req_ready = 1'b1;
        collect("sw_stall", 10);

        // Bus errors.
        io.io_mem_resp_err   = 1'b1;
        io.io_mem_resp_rdata = 32'hFFFF_FFFF;
        send(1'b0, SZ_H, 1'b0, 32'h2000, 32'h0, 5'd10, 1'b1,
             mk(32'h0, 5'd10, 1'b1, 4'd5, 3, 1'b1, 32'h2000, 4'b0000, 32'h0, 1'b0));
        collect("lhu_fault", 10);
        send(1'b1, SZ_B, 1'b0, 32'h2003, 32'h0000_0011, 5'd11, 1'b1,
             mk(32'h0, 5'd0, 1'b1, 4'd7, 3, 1'b1, 32'h2000, 4'b1000, 32'h1100_0000, 1'b1));
        collect("sb_fault", 10);
        io.io_mem_resp_err   = 1'b0;

`ifdef LSU_TIMEOUT_EN
        io.io_mem_resp_valid = 1'b0;
        send(1'b0, SZ_H, 1'b0, 32'h2000, 32'h0, 5'd12, 1'b1,
             mk(32'h0, 5'd12, 1'b1, 4'd5, 66, 1'b1, 32'h2000, 4'b0000, 32'h0, 1'b0));
        collect("lhu_timeout", 80);
        io.io_mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("late_after_timeout", 32'(io.io_resp_valid), 32'd0);
        end
`endif

        // Reset while waiting for a response; the late response must be dropped.
        io.io_mem_resp_valid = 1'b0;
        send(1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0, 5'd13, 1'b0,
             mk(32'h0, 5'd0, 1'b0, 4'd0, 0, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0));
        repeat (2) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("wait_hold_resp",  32'(io.io_resp_valid), 32'd0);
            chk("wait_hold_ready", 32'(io.io_req_ready), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("async_rst_ready",     32'(io.io_req_ready), 32'd1);
        chk("async_rst_mem_valid", 32'(io.io_mem_req_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        io.io_mem_resp_rdata = 32'h1234_5678;
        io.io_mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("late_resp_ignored", 32'(io.io_resp_valid), 32'd0);
        end
        send(1'b0, SZ_W, 1'b0, 32'h0000_0000, 32'h0, 5'd14, 1'b1,
             mk(32'h1234_5678, 5'd14, 1'b0, 4'd0, 3, 1'b1, 32'h0, 4'b0000, 32'h0, 1'b0));
        collect("lw_after_rst", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
